palette_ram_ctrl: RTL and testbench
===================================

PALETTE_RAM_CTRL -- requirements
Module: palette_ram_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 16, word width; multiple of 8.
- ADDR_W, 8, address bits per bank.
- BANKS, 2, number of palette banks; power of two, at least 1.
- BYPASS, 0, read/write collision mode (see REQ-016).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset; asynchronous, active-high.
- vid_rd_en_i, in, 1, video read strobe.
- vid_bank_i, in, BW = max(1, log2(BANKS)), video bank select.
- vid_rd_addr_i, in, ADDR_W, video read address.
- vid_rd_data_o, out, DATA_W, video read data.
- vid_rd_valid_o, out, 1, video read data valid.
- cpu_req_i, in, 1, CPU access request.
- cpu_we_i, in, 1, 1 = write, 0 = read.
- cpu_ben_i, in, DATA_W/8, byte enables; bit n enables byte n.
- cpu_addr_i, in, BW+ADDR_W, address; upper BW bits = bank.
- cpu_wr_data_i, in, DATA_W, CPU write data.
- cpu_rd_data_o, out, DATA_W, CPU read data.
- cpu_ack_o, out, 1, access complete.
- fill_start_i, in, 1, start a bulk fill.
- fill_data_i, in, DATA_W, fill value.
- busy_o, out, 1, fill in progress.

Function
REQ-003 Storage SHALL be BANKS*2^ADDR_W words of DATA_W bits, holding no reset state and initialised to zero at configuration.
REQ-004 Video read SHALL have 1-cycle latency: vid_rd_en_i=1 at edge N loads vid_rd_data_o with word {vid_bank_i, vid_rd_addr_i}, visible after edge N.
REQ-005 vid_rd_valid_o SHALL equal vid_rd_en_i registered 1 cycle.
REQ-006 vid_rd_data_o SHALL hold its value while vid_rd_en_i=0.
REQ-007 The video port SHALL never stall, including during fill.
REQ-008 The control FSM SHALL have the states IDLE, ACK and FILL.
REQ-009 In IDLE, fill_start_i=1 SHALL take priority over cpu_req_i: capture fill_data_i, clear the fill counter, go to FILL.
REQ-010 In IDLE with cpu_req_i=1 and fill_start_i=0, the access SHALL be accepted.
- Write: each byte n with cpu_ben_i[n]=1 is updated at that edge; others are unchanged.
- Read: the addressed word is registered into cpu_rd_data_o.
- The FSM then goes to ACK.
REQ-011 In ACK, cpu_ack_o SHALL be 1 for exactly one cycle with cpu_rd_data_o valid for reads, then return to IDLE.
REQ-012 The requester SHALL hold request inputs stable until ack; a cpu_req_i still high in the cycle after ACK SHALL be treated as a new request.
REQ-013 cpu_rd_data_o SHALL hold its last read value until the next accepted read; writes SHALL leave it unchanged.
REQ-014 In FILL, one word per cycle SHALL be written with the captured fill value, all bytes enabled, at linear address = counter, from 0 to BANKS*2^ADDR_W-1.
- After the last word is written, go to IDLE.
- Fill duration is exactly BANKS*2^ADDR_W cycles.
REQ-015 busy_o SHALL be 1 exactly while in FILL.
- cpu_req_i is not accepted and cpu_ack_o stays 0 during FILL.
- fill_start_i is ignored during FILL.
- A request pending at fill end is accepted in the first IDLE cycle.
REQ-016 On a same-cycle video read and write (CPU or fill) to the same address:
- BYPASS=0: vid_rd_data_o returns the old word.
- BYPASS=1: vid_rd_data_o returns the old word with the written bytes replaced by the new data.
REQ-017 A CPU read of the address written in the immediately preceding access SHALL return the updated data.
REQ-018 The counter SHALL be wide enough to index all words without wrap; its terminal count SHALL end FILL rather than wrap to 0.

Reset
REQ-019 rst_i=1 SHALL asynchronously force: FSM to IDLE, fill counter to 0, and vid_rd_data_o, vid_rd_valid_o, cpu_rd_data_o, cpu_ack_o and busy_o to 0.
REQ-020 Reset during FILL SHALL abort the fill; words already written keep the fill value, the rest are unchanged.
REQ-021 Reset during ACK SHALL drop cpu_ack_o immediately; the write accepted before reset SHALL persist.
REQ-022 Memory contents SHALL NOT be altered by reset.

Verification
REQ-023 CPU write 0x1234 to bank 1 addr 0x05 with ben=2'b11, then ben=2'b01 with data 0xFFAA; read back -> ack 1 cycle after each acceptance; read data 0x12AA.
REQ-024 Video reads of addr 0..255 on consecutive cycles, bank 0 -> data and valid 1 cycle after each strobe, gapless; data holds when the strobe drops.
REQ-025 fill_start_i with fill_data_i 0x0F0F, cpu_req_i raised mid-fill -> busy_o high exactly 512 cycles (defaults), CPU ack only after busy_o falls, all words read 0x0F0F.
REQ-026 Collision: video read and CPU write of 0xBEEF to the same address holding 0x1111, ben=2'b10 -> BYPASS=0 returns 0x1111; BYPASS=1 returns 0xBE11.
REQ-027 rst_i asserted at fill count 100 -> busy_o and all outputs 0 immediately; words 0..99 hold the fill value, words 100..511 unchanged.
REQ-028 Parameter sweep DATA_W=24, ADDR_W=4, BANKS=4 -> byte-lane writes correct on all 3 lanes; fill covers 64 words.

Source files
------------

// File: rtl/palette_ram_ctrl.sv
// Dual-ported palette RAM: a never-stalling video read port plus a CPU port
// sharing the single write path with a bulk-fill engine.
module palette_ram_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int BANKS  = 2,
    parameter int BYPASS = 0,
    localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   vid_rd_en_i,
    input  logic [BW-1:0]          vid_bank_i,
    input  logic [ADDR_W-1:0]      vid_rd_addr_i,
    output logic [DATA_W-1:0]      vid_rd_data_o,
    output logic                   vid_rd_valid_o,
    input  logic                   cpu_req_i,
    input  logic                   cpu_we_i,
    input  logic [DATA_W/8-1:0]    cpu_ben_i,
    input  logic [BW+ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]      cpu_wr_data_i,
    output logic [DATA_W-1:0]      cpu_rd_data_o,
    output logic                   cpu_ack_o,
    input  logic                   fill_start_i,
    input  logic [DATA_W-1:0]      fill_data_i,
    output logic                   busy_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = ADDR_W + ((BANKS > 1) ? $clog2(BANKS) : 0);
    localparam int DEPTH = BANKS * (2 ** ADDR_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ACK, FILL} state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    fill_cnt;
    logic [DATA_W-1:0]   fill_val;

    logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]    vid_idx;
    logic [IDX_W-1:0]    cpu_idx;
    logic                cpu_accept;
    logic                fill_go;

    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [BYTES-1:0]    wr_ben;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   vid_word;

    // With a single bank the bank select bit carries no address information.
    assign vid_idx    = IDX_W'({vid_bank_i, vid_rd_addr_i});
    assign cpu_idx    = IDX_W'(cpu_addr_i);
    assign fill_go    = (state == IDLE) && fill_start_i;
    assign cpu_accept = (state == IDLE) && cpu_req_i && !fill_start_i;

    assign cpu_ack_o  = (state == ACK);
    assign busy_o     = (state == FILL);

    // Fill and CPU writes share one write port; reset blocks any write so
    // memory contents survive it untouched.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cpu_idx;
        wr_ben  = cpu_ben_i;
        wr_data = cpu_wr_data_i;
        if (state == FILL) begin
            wr_en   = 1'b1;
            wr_idx  = fill_cnt;
            wr_ben  = '1;
            wr_data = fill_val;
        end else if (cpu_accept && cpu_we_i) begin
            wr_en = 1'b1;
        end
        if (rst_i) begin
            wr_en = 1'b0;
        end
    end

    always_comb begin
        vid_word = mem[vid_idx];
        if ((BYPASS != 0) && wr_en && (wr_idx == vid_idx)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_ben[b]) begin
                    vid_word[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_ben[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fill_start_i) begin
                    state_next = FILL;
                end else if (cpu_req_i) begin
                    state_next = ACK;
                end
            end
            ACK:  state_next = IDLE;
            FILL: begin
                if (fill_cnt == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter parks at its terminal value; the next fill clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_cnt      <= '0;
            fill_val      <= '0;
            cpu_rd_data_o <= '0;
        end else begin
            if (fill_go) begin
                fill_val <= fill_data_i;
                fill_cnt <= '0;
            end else if ((state == FILL) && (fill_cnt != LAST_IDX)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (cpu_accept && !cpu_we_i) begin
                cpu_rd_data_o <= mem[cpu_idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_rd_data_o  <= '0;
            vid_rd_valid_o <= 1'b0;
        end else begin
            vid_rd_valid_o <= vid_rd_en_i;
            if (vid_rd_en_i) begin
                vid_rd_data_o <= vid_word;
            end
        end
    end

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// Directed self-checking bench for palette_ram_ctrl: default build, a BYPASS=1
// twin sharing its inputs, and a 24-bit / 4-bank build.
module tb_palette_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        vid_rd_en = 1'b0;
    logic        vid_bank = 1'b0;
    logic [7:0]  vid_rd_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_ben = '0;
    logic [8:0]  cpu_addr = '0;
    logic [15:0] cpu_wr_data = '0;
    logic        fill_start = 1'b0;
    logic [15:0] fill_data = '0;

    logic [15:0] vid_rd_data0, vid_rd_data1, cpu_rd_data0, cpu_rd_data1;
    logic        vid_rd_valid0, vid_rd_valid1, cpu_ack0, cpu_ack1, busy0, busy1;

    logic        s_vid_rd_en = 1'b0;
    logic [1:0]  s_vid_bank = '0;
    logic [3:0]  s_vid_rd_addr = '0;
    logic        s_cpu_req = 1'b0;
    logic        s_cpu_we = 1'b0;
    logic [2:0]  s_cpu_ben = '0;
    logic [5:0]  s_cpu_addr = '0;
    logic [23:0] s_cpu_wr_data = '0;
    logic        s_fill_start = 1'b0;
    logic [23:0] s_fill_data = '0;
    logic [23:0] s_vid_rd_data, s_cpu_rd_data;
    logic        s_vid_rd_valid, s_cpu_ack, s_busy;

    logic [15:0] model [512];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    palette_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .BANKS(2), .BYPASS(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .vid_rd_en_i(vid_rd_en), .vid_bank_i(vid_bank), .vid_rd_addr_i(vid_rd_addr),
        .vid_rd_data_o(vid_rd_data0), .vid_rd_valid_o(vid_rd_valid0),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_ben_i(cpu_ben), .cpu_addr_i(cpu_addr),
        .cpu_wr_data_i(cpu_wr_data), .cpu_rd_data_o(cpu_rd_data0), .cpu_ack_o(cpu_ack0),
        .fill_start_i(fill_start), .fill_data_i(fill_data), .busy_o(busy0));

    palette_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .BANKS(2), .BYPASS(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .vid_rd_en_i(vid_rd_en), .vid_bank_i(vid_bank), .vid_rd_addr_i(vid_rd_addr),
        .vid_rd_data_o(vid_rd_data1), .vid_rd_valid_o(vid_rd_valid1),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_ben_i(cpu_ben), .cpu_addr_i(cpu_addr),
        .cpu_wr_data_i(cpu_wr_data), .cpu_rd_data_o(cpu_rd_data1), .cpu_ack_o(cpu_ack1),
        .fill_start_i(fill_start), .fill_data_i(fill_data), .busy_o(busy1));

    palette_ram_ctrl #(.DATA_W(24), .ADDR_W(4), .BANKS(4), .BYPASS(0)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .vid_rd_en_i(s_vid_rd_en), .vid_bank_i(s_vid_bank), .vid_rd_addr_i(s_vid_rd_addr),
        .vid_rd_data_o(s_vid_rd_data), .vid_rd_valid_o(s_vid_rd_valid),
        .cpu_req_i(s_cpu_req), .cpu_we_i(s_cpu_we), .cpu_ben_i(s_cpu_ben), .cpu_addr_i(s_cpu_addr),
        .cpu_wr_data_i(s_cpu_wr_data), .cpu_rd_data_o(s_cpu_rd_data), .cpu_ack_o(s_cpu_ack),
        .fill_start_i(s_fill_start), .fill_data_i(s_fill_data), .busy_o(s_busy));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One CPU access on the default build, with ack timing checked and the
    // reference model updated for writes.
    task automatic applyStimulus(input logic we, input logic [8:0] addr, input logic [1:0] ben,
                                 input logic [15:0] data, output logic [15:0] rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_ben = ben; cpu_wr_data = data;
        step();
        checkOutput("cpu_ack", {31'd0, cpu_ack0}, 32'd1);
        rd = cpu_rd_data0;
        cpu_req = 1'b0;
        step();
        checkOutput("cpu_ack_clear", {31'd0, cpu_ack0}, 32'd0);
        if (we) begin
            for (int b = 0; b < 2; b++) begin
                if (ben[b]) model[addr][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic s_access(input logic we, input logic [5:0] addr, input logic [2:0] ben,
                            input logic [23:0] data, output logic [23:0] rd);
        s_cpu_req = 1'b1; s_cpu_we = we; s_cpu_addr = addr; s_cpu_ben = ben; s_cpu_wr_data = data;
        step();
        checkOutput("s_cpu_ack", {31'd0, s_cpu_ack}, 32'd1);
        rd = s_cpu_rd_data;
        s_cpu_req = 1'b0;
        step();
        checkOutput("s_cpu_ack_clear", {31'd0, s_cpu_ack}, 32'd0);
    endtask

    task automatic video_sweep(input int first, input int count);
        int last;
        last = first;
        for (int i = first; i < first + count; i++) begin
            vid_rd_en = 1'b1; vid_bank = i[8]; vid_rd_addr = i[7:0];
            step();
            checkOutput("vid_valid", {31'd0, vid_rd_valid0}, 32'd1);
            checkOutput("vid_data", {16'd0, vid_rd_data0}, {16'd0, model[i]});
            checkOutput("vid_data_bypass_dut", {16'd0, vid_rd_data1}, {16'd0, model[i]});
            last = i;
        end
        vid_rd_en = 1'b0;
        step();
        checkOutput("vid_valid_drop", {31'd0, vid_rd_valid0}, 32'd0);
        checkOutput("vid_data_hold", {16'd0, vid_rd_data0}, {16'd0, model[last]});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [23:0] srd;
        int          busy_cycles;
        int          guard;

        for (int i = 0; i < 512; i++) model[i] = '0;

        #3 rst = 1'b1;
        #2;
        checkOutput("rst_vid_data", {16'd0, vid_rd_data0}, 32'd0);
        checkOutput("rst_vid_valid", {31'd0, vid_rd_valid0}, 32'd0);
        checkOutput("rst_cpu_rd", {16'd0, cpu_rd_data0}, 32'd0);
        checkOutput("rst_ack", {31'd0, cpu_ack0}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
        step();
        step();
        rst = 1'b0;

        applyStimulus(1'b1, 9'h105, 2'b11, 16'h1234, rd);
        applyStimulus(1'b1, 9'h105, 2'b01, 16'hFFAA, rd);
        applyStimulus(1'b0, 9'h105, 2'b11, 16'h0000, rd);
        checkOutput("byte_lane_read", {16'd0, rd}, 32'h12AA);

        applyStimulus(1'b1, 9'h000, 2'b11, 16'hA5A5, rd);
        checkOutput("rd_hold_on_write", {16'd0, cpu_rd_data0}, 32'h12AA);
        applyStimulus(1'b1, 9'h0FF, 2'b11, 16'h5A5A, rd);
        applyStimulus(1'b1, 9'h010, 2'b10, 16'h34FF, rd);
        applyStimulus(1'b0, 9'h010, 2'b11, 16'h0000, rd);
        checkOutput("read_after_write", {16'd0, rd}, 32'h3400);

        video_sweep(0, 256);
        video_sweep(9'h105, 1);

        applyStimulus(1'b1, 9'h020, 2'b11, 16'h1111, rd);
        vid_rd_en = 1'b1; vid_bank = 1'b0; vid_rd_addr = 8'h20;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_ben = 2'b10; cpu_wr_data = 16'hBEEF;
        step();
        checkOutput("collide_old_word", {16'd0, vid_rd_data0}, 32'h1111);
        checkOutput("collide_bypass_word", {16'd0, vid_rd_data1}, 32'hBE11);
        checkOutput("collide_ack", {31'd0, cpu_ack0}, 32'd1);
        cpu_req = 1'b0; vid_rd_en = 1'b0;
        step();
        model[9'h020] = 16'hBE11;
        video_sweep(9'h020, 1);

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_ben = 2'b11; cpu_wr_data = 16'h7777;
        step();
        checkOutput("ack_before_rst", {31'd0, cpu_ack0}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("ack_rst_drop", {31'd0, cpu_ack0}, 32'd0);
        cpu_req = 1'b0;
        step();
        rst = 1'b0;
        model[9'h040] = 16'h7777;
        video_sweep(9'h040, 1);

        fill_data = 16'h0F0F; fill_start = 1'b1;
        vid_rd_en = 1'b1; vid_bank = 1'b1; vid_rd_addr = 8'h05;
        step();
        fill_start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (busy0 && guard < 2000) begin
            busy_cycles++;
            if (busy_cycles == 200) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1FF;
            end
            checkOutput("ack_during_fill", {31'd0, cpu_ack0}, 32'd0);
            checkOutput("vid_valid_during_fill", {31'd0, vid_rd_valid0}, 32'd1);
            step();
            guard++;
        end
        vid_rd_en = 1'b0;
        checkOutput("fill_length", busy_cycles, 32'd512);
        checkOutput("ack_at_fill_end", {31'd0, cpu_ack0}, 32'd0);
        step();
        checkOutput("ack_after_fill", {31'd0, cpu_ack0}, 32'd1);
        checkOutput("rd_after_fill", {16'd0, cpu_rd_data0}, 32'h0F0F);
        cpu_req = 1'b0;
        step();
        for (int i = 0; i < 512; i++) model[i] = 16'h0F0F;
        video_sweep(0, 512);

        fill_data = 16'h3C3C; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        vid_rd_en = 1'b1; vid_bank = 1'b1; vid_rd_addr = 8'h2C;
        repeat (100) step();
        checkOutput("busy_before_abort", {31'd0, busy0}, 32'd1);
        checkOutput("vid_before_abort", {16'd0, vid_rd_data0}, 32'h0F0F);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy0}, 32'd0);
        checkOutput("abort_vid_valid", {31'd0, vid_rd_valid0}, 32'd0);
        checkOutput("abort_vid_data", {16'd0, vid_rd_data0}, 32'd0);
        checkOutput("abort_cpu_rd", {16'd0, cpu_rd_data0}, 32'd0);
        checkOutput("abort_ack", {31'd0, cpu_ack0}, 32'd0);
        vid_rd_en = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) model[i] = 16'h3C3C;
        video_sweep(0, 512);

        s_access(1'b1, 6'h35, 3'b111, 24'hAABBCC, srd);
        s_access(1'b1, 6'h35, 3'b010, 24'h112233, srd);
        s_access(1'b0, 6'h35, 3'b000, 24'h000000, srd);
        checkOutput("s_lane1", {8'd0, srd}, 32'hAA22CC);
        s_access(1'b1, 6'h35, 3'b100, 24'h445566, srd);
        s_access(1'b0, 6'h35, 3'b000, 24'h000000, srd);
        checkOutput("s_lane2", {8'd0, srd}, 32'h4422CC);
        s_access(1'b1, 6'h35, 3'b001, 24'h778899, srd);
        s_access(1'b0, 6'h35, 3'b000, 24'h000000, srd);
        checkOutput("s_lane0", {8'd0, srd}, 32'h442299);
        s_access(1'b0, 6'h15, 3'b000, 24'h000000, srd);
        checkOutput("s_other_bank", {8'd0, srd}, 32'h000000);

        s_fill_data = 24'h123456; s_fill_start = 1'b1;
        step();
        s_fill_start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (s_busy && guard < 500) begin
            busy_cycles++;
            step();
            guard++;
        end
        checkOutput("s_fill_length", busy_cycles, 32'd64);
        for (int i = 0; i < 64; i++) begin
            s_vid_rd_en = 1'b1; s_vid_bank = i[5:4]; s_vid_rd_addr = i[3:0];
            step();
            checkOutput("s_fill_word", {8'd0, s_vid_rd_data}, 32'h123456);
        end
        s_vid_rd_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
